fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the PC and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the PC value loaded on reset.
REQ-003 SHALL have parameter NOP, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the performance counters.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port PCWrite, input, 1 bit: PC update enable from hazard detection.
REQ-009 SHALL have port IDWrite, input, 1 bit: IF/ID register update enable from hazard detection.
REQ-010 SHALL have port Flush, input, 1 bit: taken branch or jump resolved downstream.
REQ-011 SHALL have port Target, input, DATA_WIDTH bits: redirect address, valid with Flush.
REQ-012 SHALL have port IMem_Data, input, DATA_WIDTH bits: instruction at IMem_Addr.
REQ-013 SHALL have port IMem_Ready, input, 1 bit: IMem_Data is valid this cycle.
REQ-014 SHALL have port IMem_Addr, output, DATA_WIDTH bits: the current PC, driven combinationally.
REQ-015 SHALL have port D_PC, output, DATA_WIDTH bits: registered PC of the instruction in ID.
REQ-016 SHALL have port D_PC4, output, DATA_WIDTH bits: registered D_PC+4.
REQ-017 SHALL have port D_Instr, output, DATA_WIDTH bits: registered instruction in ID.
REQ-018 SHALL have port D_Valid, output, 1 bit: D_Instr is a real instruction, not a bubble.
REQ-019 SHALL have port Stall_Count, output, CNT_WIDTH bits: number of stall cycles.
REQ-020 SHALL have port Flush_Count, output, CNT_WIDTH bits: number of flush cycles.

Function
REQ-021 SHALL hold PC in a register and drive IMem_Addr = PC.
REQ-022 SHALL evaluate each cycle in priority order Flush > IMem_Ready low > PCWrite/IDWrite.
REQ-023 On Flush=1, regardless of PCWrite/IDWrite/IMem_Ready, SHALL set PC <= {Target[DATA_WIDTH-1:2],2'b00}, D_Instr <= NOP, D_Valid <= 0, D_PC <= PC, D_PC4 <= PC+4.
REQ-024 On Flush=0 and IMem_Ready=0, SHALL hold PC; if IDWrite=1, SHALL load D_Instr <= NOP and D_Valid <= 0; if IDWrite=0, SHALL hold all D_* outputs.
REQ-025 On Flush=0, IMem_Ready=1 and PCWrite=1, SHALL set PC <= PC+4 (modulo 2^DATA_WIDTH; wrap from 32'hFFFF_FFFC to 0).
REQ-026 On Flush=0, IMem_Ready=1 and IDWrite=1, SHALL load D_Instr <= IMem_Data, D_PC <= PC, D_PC4 <= PC+4 and D_Valid <= 1.
REQ-027 On Flush=0, IMem_Ready=1, PCWrite=0 and IDWrite=0 (load-use stall), SHALL hold PC and all D_* outputs, so the stalled instruction is re-presented the next cycle.
REQ-028 SHALL give a fetch-to-ID latency of 1 cycle: the instruction at PC appears on D_Instr the cycle after IMem_Ready=1 with IDWrite=1.
REQ-029 SHALL increment Stall_Count by 1 in each cycle with Flush=0 and (PCWrite=0 or IMem_Ready=0), saturating at all-ones.
REQ-030 SHALL increment Flush_Count by 1 in each cycle with Flush=1, saturating at all-ones.
REQ-031 SHALL NOT wrap either counter at saturation.
REQ-032 SHALL have all outputs other than IMem_Addr registered.

Reset
REQ-033 While rst_n=0, SHALL hold PC=RESET_PC, D_PC=0, D_PC4=0, D_Instr=NOP, D_Valid=0, Stall_Count=0 and Flush_Count=0, asynchronously.
REQ-034 SHALL abandon any stall, flush or redirect in progress when reset asserts mid-operation.
REQ-035 In the first cycle after reset deasserts, SHALL drive IMem_Addr=RESET_PC.

Verification
REQ-036 Reset then 3 cycles with IMem_Ready=1, PCWrite=IDWrite=1 -> IMem_Addr steps 0x400000, 0x400004, 0x400008; D_PC=0x400000 in the second cycle with D_Valid=1.
REQ-037 Load-use stall of 1 cycle (PCWrite=IDWrite=0) -> PC and D_Instr unchanged for that cycle, then resume; Stall_Count=1.
REQ-038 Flush=1 with Target=0x400103 asserted together with PCWrite=0 -> next PC=0x400100, D_Instr=0x00000013, D_Valid=0, Flush_Count=1, Stall_Count unchanged.
REQ-039 IMem_Ready=0 for 2 cycles with IDWrite=1 -> PC held, two bubbles (D_Valid=0), Stall_Count=2.
REQ-040 Start from PC=0xFFFFFFFC (via Flush) and advance -> PC=0x00000000; Stall_Count preset near 0xFFFF by 70000 stall cycles -> stays 0xFFFF.
REQ-041 Assert rst_n=0 mid-stall -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of an in-order pipeline. Holds the program counter,
// presents it to instruction memory, and captures the returned instruction
// into the IF/ID pipeline register. Also keeps two saturating performance
// counters for stall and flush cycles.
//
// Each cycle is handled in priority order:
//   1. Flush.
//   2. Instruction memory not ready.
//   3. Normal PCWrite / IDWrite control from hazard detection.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   PCWrite      in   PC update enable (hazard unit)
//   IDWrite      in   IF/ID register update enable (hazard unit)
//   Flush        in   redirect from a taken branch/jump resolved downstream
//   Target       in   redirect address, valid with Flush
//   IMem_Data    in   instruction at IMem_Addr
//   IMem_Ready   in   IMem_Data valid this cycle
//   IMem_Addr    out  current PC (combinational from the PC register)
//   D_PC         out  PC of the instruction held in ID
//   D_PC4        out  D_PC + 4
//   D_Instr      out  instruction held in ID (NOP when a bubble)
//   D_Valid      out  D_Instr is a real instruction
//   Stall_Count  out  saturating count of stall cycles
//   Flush_Count  out  saturating count of flush cycles
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned               DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_PC   = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0]     NOP        = 32'h0000_0013,
  parameter int unsigned               CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCWrite,
  input  logic                  IDWrite,
  input  logic                  Flush,
  input  logic [DATA_WIDTH-1:0] Target,
  input  logic [DATA_WIDTH-1:0] IMem_Data,
  input  logic                  IMem_Ready,
  output logic [DATA_WIDTH-1:0] IMem_Addr,
  output logic [DATA_WIDTH-1:0] D_PC,
  output logic [DATA_WIDTH-1:0] D_PC4,
  output logic [DATA_WIDTH-1:0] D_Instr,
  output logic                  D_Valid,
  output logic [CNT_WIDTH-1:0]  Stall_Count,
  output logic [CNT_WIDTH-1:0]  Flush_Count
);

  // Per-cycle action, decoded once so the priority order lives in one place.
  typedef enum logic [1:0] {
    ACT_FLUSH,
    ACT_WAIT,
    ACT_RUN
  } act_e;

  act_e act;

  logic [DATA_WIDTH-1:0] pc_q,      pc_d;
  logic [DATA_WIDTH-1:0] d_pc_q,    d_pc_d;
  logic [DATA_WIDTH-1:0] d_pc4_q,   d_pc4_d;
  logic [DATA_WIDTH-1:0] d_instr_q, d_instr_d;
  logic                  d_valid_q, d_valid_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  stall_evt;

  // Redirect targets are forced word-aligned; the low bits are dropped.
  logic [1:0] unused_target_lsbs;
  assign unused_target_lsbs = Target[1:0];

  // Wraps naturally modulo 2^DATA_WIDTH.
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  always_comb begin
    act = ACT_RUN;
    if (Flush) begin
      act = ACT_FLUSH;
    end else if (!IMem_Ready) begin
      act = ACT_WAIT;
    end
  end

  // A stall cycle is any non-flush cycle where the PC does not advance.
  assign stall_evt = !Flush && (!PCWrite || !IMem_Ready);

  always_comb begin
    pc_d      = pc_q;
    d_pc_d    = d_pc_q;
    d_pc4_d   = d_pc4_q;
    d_instr_d = d_instr_q;
    d_valid_d = d_valid_q;

    unique case (act)
      ACT_FLUSH: begin
        pc_d      = {Target[DATA_WIDTH-1:2], 2'b00};
        d_pc_d    = pc_q;
        d_pc4_d   = pc_plus4;
        d_instr_d = NOP;
        d_valid_d = 1'b0;
      end
      ACT_WAIT: begin
        // Memory not ready: PC holds; an enabled IF/ID register takes a
        // bubble, while D_PC/D_PC4 keep their previous values.
        if (IDWrite) begin
          d_instr_d = NOP;
          d_valid_d = 1'b0;
        end
      end
      ACT_RUN: begin
        if (PCWrite) begin
          pc_d = pc_plus4;
        end
        if (IDWrite) begin
          d_pc_d    = pc_q;
          d_pc4_d   = pc_plus4;
          d_instr_d = IMem_Data;
          d_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if (Flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      d_pc_q      <= '0;
      d_pc4_q     <= '0;
      d_instr_q   <= NOP;
      d_valid_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      d_pc_q      <= d_pc_d;
      d_pc4_q     <= d_pc4_d;
      d_instr_q   <= d_instr_d;
      d_valid_q   <= d_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign IMem_Addr   = pc_q;
  assign D_PC        = d_pc_q;
  assign D_PC4       = d_pc4_q;
  assign D_Instr     = d_instr_q;
  assign D_Valid     = d_valid_q;
  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed test for fetch_stage: a table of single-cycle vectors walked in
// order (each row's expected values follow from the previous rows), then
// hand-written sequences for counter saturation and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOPI   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        PCWrite;
  logic        IDWrite;
  logic        Flush;
  logic [31:0] Target;
  logic [31:0] IMem_Data;
  logic        IMem_Ready;
  logic [31:0] IMem_Addr;
  logic [31:0] D_PC;
  logic [31:0] D_PC4;
  logic [31:0] D_Instr;
  logic        D_Valid;
  logic [15:0] Stall_Count;
  logic [15:0] Flush_Count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(
    .DATA_WIDTH (32),
    .RESET_PC   (RST_PC),
    .NOP        (NOPI),
    .CNT_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCWrite     (PCWrite),
    .IDWrite     (IDWrite),
    .Flush       (Flush),
    .Target      (Target),
    .IMem_Data   (IMem_Data),
    .IMem_Ready  (IMem_Ready),
    .IMem_Addr   (IMem_Addr),
    .D_PC        (D_PC),
    .D_PC4       (D_PC4),
    .D_Instr     (D_Instr),
    .D_Valid     (D_Valid),
    .Stall_Count (Stall_Count),
    .Flush_Count (Flush_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        pcw;
    logic        idw;
    logic        rdy;
    logic [31:0] tgt;
    logic [31:0] data;
    logic [31:0] e_addr;
    logic [31:0] e_dpc;
    logic [31:0] e_dpc4;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [15:0] e_stall;
    logic [15:0] e_flush;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_dpc,
                           input logic [31:0] e_dpc4, input logic [31:0] e_instr, input logic e_valid,
                           input logic [15:0] e_stall, input logic [15:0] e_flush);
    check({tag, "_addr"},  IMem_Addr, e_addr);
    check({tag, "_dpc"},   D_PC, e_dpc);
    check({tag, "_dpc4"},  D_PC4, e_dpc4);
    check({tag, "_instr"}, D_Instr, e_instr);
    check({tag, "_valid"}, {31'd0, D_Valid}, {31'd0, e_valid});
    check({tag, "_stall"}, {16'd0, Stall_Count}, {16'd0, e_stall});
    check({tag, "_flush"}, {16'd0, Flush_Count}, {16'd0, e_flush});
  endtask

  task automatic drive(input logic fl, input logic pcw, input logic idw, input logic rdy,
                       input logic [31:0] tgt, input logic [31:0] data);
    Flush      = fl;
    PCWrite    = pcw;
    IDWrite    = idw;
    IMem_Ready = rdy;
    Target     = tgt;
    IMem_Data  = data;
  endtask

  initial begin
    //            fl   pcw  idw  rdy  target        data          addr          dpc           dpc4          instr         v    stall  flush
    vecs[0]  = '{1'b0,1'b1,1'b1,1'b1,32'h0,        32'h1111_1111,32'h0040_0004,32'h0040_0000,32'h0040_0004,32'h1111_1111,1'b1,16'd0,16'd0};
    vecs[1]  = '{1'b0,1'b1,1'b1,1'b1,32'h0,        32'h2222_2222,32'h0040_0008,32'h0040_0004,32'h0040_0008,32'h2222_2222,1'b1,16'd0,16'd0};
    // load-use stall: nothing moves
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,        32'h3333_3333,32'h0040_0008,32'h0040_0004,32'h0040_0008,32'h2222_2222,1'b1,16'd1,16'd0};
    vecs[3]  = '{1'b0,1'b1,1'b1,1'b1,32'h0,        32'h3333_3333,32'h0040_000C,32'h0040_0008,32'h0040_000C,32'h3333_3333,1'b1,16'd1,16'd0};
    // flush wins over PCWrite=0; target low bits cleared
    vecs[4]  = '{1'b1,1'b0,1'b1,1'b1,32'h0040_0103,32'h4444_4444,32'h0040_0100,32'h0040_000C,32'h0040_0010,NOPI,         1'b0,16'd1,16'd1};
    // two memory-wait cycles with IDWrite: bubbles, D_PC held
    vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        32'hDEAD_BEEF,32'h0040_0100,32'h0040_000C,32'h0040_0010,NOPI,         1'b0,16'd2,16'd1};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        32'hDEAD_BEEF,32'h0040_0100,32'h0040_000C,32'h0040_0010,NOPI,         1'b0,16'd3,16'd1};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,32'h0,        32'h5555_5555,32'h0040_0104,32'h0040_0100,32'h0040_0104,32'h5555_5555,1'b1,16'd3,16'd1};
    // memory wait with IDWrite=0: ID held as-is
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'hDEAD_BEEF,32'h0040_0104,32'h0040_0100,32'h0040_0104,32'h5555_5555,1'b1,16'd4,16'd1};
    // PC advances, ID held
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,32'h0,        32'hDEAD_BEEF,32'h0040_0108,32'h0040_0100,32'h0040_0104,32'h5555_5555,1'b1,16'd4,16'd1};
    // PC held, ID loads (counts as a stall)
    vecs[10] = '{1'b0,1'b0,1'b1,1'b1,32'h0,        32'h6666_6666,32'h0040_0108,32'h0040_0108,32'h0040_010C,32'h6666_6666,1'b1,16'd5,16'd1};
    // flush to top of address space, IMem not ready ignored
    vecs[11] = '{1'b1,1'b1,1'b1,1'b0,32'hFFFF_FFFE,32'hDEAD_BEEF,32'hFFFF_FFFC,32'h0040_0108,32'h0040_010C,NOPI,         1'b0,16'd5,16'd2};
    // PC and D_PC4 wrap to zero
    vecs[12] = '{1'b0,1'b1,1'b1,1'b1,32'h0,        32'h7777_7777,32'h0000_0000,32'hFFFF_FFFC,32'h0000_0000,32'h7777_7777,1'b1,16'd5,16'd2};
    vecs[13] = '{1'b0,1'b1,1'b1,1'b1,32'h0,        32'h8888_8888,32'h0000_0004,32'h0000_0000,32'h0000_0004,32'h8888_8888,1'b1,16'd5,16'd2};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("rst", RST_PC, 32'h0, 32'h0, NOPI, 1'b0, 16'd0, 16'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_addr", IMem_Addr, RST_PC);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].fl, vecs[i].pcw, vecs[i].idw, vecs[i].rdy, vecs[i].tgt, vecs[i].data);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_dpc, vecs[i].e_dpc4,
                vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_stall, vecs[i].e_flush);
    end

    // Stall counter saturation: 5 + 70000 stall cycles exceeds 0xFFFF.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    repeat (70000) @(posedge clk);
    #1;
    check_all("sat", 32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 32'h8888_8888, 1'b1, 16'hFFFF, 16'd2);
    @(posedge clk);
    #1;
    check("sat_hold_stall", {16'd0, Stall_Count}, 32'h0000_FFFF);

    // Asynchronous reset in the middle of a stall, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", RST_PC, 32'h0, 32'h0, NOPI, 1'b0, 16'd0, 16'd0);
    @(posedge clk);
    #1;
    check("rst_hold_addr", IMem_Addr, RST_PC);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h9999_9999);
    rst_n = 1'b1;
    #1;
    check("rel_addr", IMem_Addr, RST_PC);
    @(posedge clk);
    #1;
    check_all("resume", 32'h0040_0004, RST_PC, 32'h0040_0004, 32'h9999_9999, 1'b1, 16'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
